// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Contents: funct3 encodings, FSM state type, operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle of the multiply/divide unit.
// master: drives in_valid, funct3, a, b, out_ready; slave: drives in_ready, out_valid, result, busy.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, funct3, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// Shared iterative datapath: shift-and-add multiply (LSB first) and restoring divide (MSB first).
// Ports: clk, rst (async high); load latches magnitudes and mode; step runs one iteration.
// Outputs: product {acc, lo}, quotient lo, remainder acc.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] product,
    output logic [XLEN-1:0]   quotient,
    output logic [XLEN-1:0]   remainder
);
    // acc: product high half / partial remainder; lo: multiplier->product low / dividend->quotient
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
    logic            div_q, div_d;
    logic [XLEN:0]   add_sum, trial, sub_diff;

    always_comb begin
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        div_d    = div_q;
        add_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        trial    = {acc_q, lo_q[XLEN-1]};
        sub_diff = trial - {1'b0, opnd_q};
        if (load) begin
            acc_d = '0;
            div_d = is_div;
            if (is_div) begin
                lo_d   = a_mag;
                opnd_d = b_mag;
            end else begin
                lo_d   = b_mag;
                opnd_d = a_mag;
            end
        end else if (step) begin
            if (div_q) begin
                // Borrow out (MSB set) means the divisor did not fit: restore.
                acc_d = sub_diff[XLEN] ? trial[XLEN-1:0] : sub_diff[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], ~sub_diff[XLEN]};
            end else begin
                // Shift {carry, acc+addend, lo} right by one.
                {acc_d, lo_d} = {add_sum, lo_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign product   = {acc_q, lo_q};
    assign quotient  = lo_q;
    assign remainder = acc_q;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit.
// Ports: clk, rst (async high), bus (muldiv_if.slave: in_valid/in_ready/funct3/a/b request,
// out_valid/out_ready/result response, busy status).
// Holds the FSM, operand sign handling, early-out special cases and the sign-fix stage.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam int unsigned    CW      = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic              a_neg, b_neg, div_zero, sgn_ovf, core_load, core_step;
    logic [XLEN-1:0]   a_mag, b_mag, quotient, remainder, quo_fix, rem_fix;
    logic [2*XLEN-1:0] product, prod_fix;

    muldiv_iter_core #(
        .XLEN(XLEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .step     (core_step),
        .is_div   (bus.funct3[2]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .product  (product),
        .quotient (quotient),
        .remainder(remainder)
    );

    always_comb begin
        a_neg    = is_signed_a(bus.funct3) & bus.a[XLEN-1];
        b_neg    = is_signed_b(bus.funct3) & bus.b[XLEN-1];
        a_mag    = a_neg ? -bus.a : bus.a;
        b_mag    = b_neg ? -bus.b : bus.b;
        div_zero = bus.funct3[2] && (bus.b == '0);
        sgn_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM))
                   && (bus.a == INT_MIN) && (bus.b == '1);

        prod_fix = neg_res_q ? -product : product;
        quo_fix  = neg_res_q ? -quotient : quotient;
        rem_fix  = neg_rem_q ? -remainder : remainder;

        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        core_load   = 1'b0;
        core_step   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    f3_d      = bus.funct3;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div_zero) begin
                        // funct3[1] separates REM/REMU from DIV/DIVU
                        result_d = bus.funct3[1] ? bus.a : '1;
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        result_d = bus.funct3[1] ? '0 : bus.a;
                        state_d  = DONE;
                    end else begin
                        core_load = 1'b1;
                        cnt_d     = CW'(XLEN - 1);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                core_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                case (f3_q)
                    F3_MUL:                       result_d = prod_fix[XLEN-1:0];
                    F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
                    F3_DIV, F3_DIVU:              result_d = quo_fix;
                    default:                      result_d = rem_fix;
                endcase
                state_d = DONE;
            end
            DONE: begin
                // out_valid lags DONE entry by one edge; it drops on the handshake edge.
                if (out_valid_q && bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(
        .XLEN(XLEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural RV32M result, computed with wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, ub_s;
        logic [63:0]        p;
        int                 ia, ib;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub_s = {32'b0, b};
        ia   = a;
        ib   = b;
        case (f3)
            F3_MUL:    begin p = sa * sb;   return p[31:0];  end
            F3_MULH:   begin p = sa * sb;   return p[63:32]; end
            F3_MULHSU: begin p = sa * ub_s; return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Waits (bounded) for in_ready, presents the op, and returns just after the accept edge.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.a        = a;
        bus.b        = b;
        tick();
        bus.in_valid = 1'b0;
        bus.funct3   = 3'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Counts edges from accept until out_valid; flags in_ready/busy misbehaviour meanwhile.
    task automatic wait_valid(output int lat, output bit bad);
        lat = 0;
        bad = 1'b0;
        while (lat < 100) begin
            tick();
            lat++;
            if (bus.out_valid) break;
            if (bus.in_ready || !bus.busy) bad = 1'b1;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit bad;
        start_op(f3, a, b);
        wait_valid(lat, bad);
        check({name, "_result"}, bus.result, exp);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, bad, 1'b0);
        take();
        check({name, "_release"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    endtask

    initial begin
        int  lat;
        bit  bad;
        bit  ok;
        logic [31:0] held;
        logic [2:0]  f3;
        logic [31:0] ra, rb;

        bus.in_valid  = 1'b0;
        bus.funct3    = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset values, during and after reset
        tick();
        check("reset_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        check("reset_result", bus.result, 32'h0);
        rst = 1'b0;
        tick();
        check("post_reset_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);

        vecs = '{
            '{F3_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
            '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
            '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
            '{F3_MULHSU, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 34},
            '{F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34},
            '{F3_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34},
            '{F3_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34},
            '{F3_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34},
            '{F3_REM,    32'h7,         32'hFFFF_FFFD, 32'h1,         34},
            '{F3_DIVU,   32'd100,       32'd7,         32'd14,        34},
            '{F3_REMU,   32'd100,       32'd7,         32'd2,         34},
            '{F3_DIVU,   32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 34},
            '{F3_DIV,    32'h8000_0000, 32'h2,         32'hC000_0000, 34},
            '{F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1},
            '{F3_REMU,   32'd5,         32'd0,         32'd5,         1},
            '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1}
        };
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat);
        end

        // Backpressure: result held while out_ready low; inputs meanwhile ignored
        start_op(F3_DIVU, 32'd100, 32'd7);
        wait_valid(lat, bad);
        check("bp_first_result", bus.result, 32'd14);
        check("bp_first_latency", lat, 34);
        held = bus.result;
        ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.funct3   = 3'($urandom);
            bus.a        = $urandom;
            bus.b        = $urandom;
            tick();
            if (bus.out_valid !== 1'b1 || bus.result !== held || bus.busy !== 1'b1
                || bus.in_ready !== 1'b0) ok = 1'b0;
        end
        check("bp_stable", ok, 1'b1);
        bus.in_valid  = 1'b1;
        bus.funct3    = F3_MUL;
        bus.a         = 32'd6;
        bus.b         = 32'd7;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_no_accept_on_release", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        tick();
        bus.in_valid = 1'b0;
        wait_valid(lat, bad);
        check("bp_second_result", bus.result, 32'd42);
        check("bp_second_latency", lat, 34);
        take();

        // Reset in the middle of CALC discards the operation
        start_op(F3_MUL, 32'h0001_2345, 32'h0000_0777);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midreset_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        check("midreset_result", bus.result, 32'h0);
        tick();
        check("midreset_held_flags", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
        rst = 1'b0;
        ok  = 1'b1;
        repeat (40) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check("midreset_no_result", ok, 1'b1);
        run_op("divu_after_reset", F3_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Randomised ops against the wide-arithmetic model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_f%0d_%h_%h", i, f3, ra, rb), f3, ra, rb,
                   ref_result(f3, ra, rb), ref_latency(f3, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
